pipe_strobe_seq: RTL
====================

PIPE_STROBE_SEQ -- requirements
Module: pipe_strobe_seq

Interface
REQ-001 SHALL have parameter CS_WIDTH, default 2: strobe low-time in clk cycles, legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum wait-state cycles, legal range 2..255.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1; reset rst, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: run enable, level-sensitive, active-high.
REQ-006 SHALL have port finish, input, 1: ALU-result-pending flag from pipeline control (1=FULL, 0=EMPTY), asynchronous to clk.
REQ-007 SHALL have port goahead, input, 1: fetch-permitted flag from pipeline control (1=FULL, 0=EMPTY), asynchronous to clk.
REQ-008 SHALL have port pcir_cs, output, 1: PC/IR fetch strobe, active-low.
REQ-009 SHALL have port alu_cs, output, 1: ALU execute strobe, active-low.
REQ-010 SHALL have port busy, output, 1: high in any state except IDLE and ERR.
REQ-011 SHALL have port err, output, 1: sticky wait-state timeout flag.
REQ-012 SHALL have port instr_cnt, output, 16: count of completed fetch/execute pairs.

Function
REQ-013 SHALL pass finish and goahead through a two-flop synchronizer; all decisions use the synchronized values (fin_s, go_s).
REQ-014 SHALL implement states IDLE, FETCH, WAIT_GO, EXEC, WAIT_FIN, ERR as a Moore FSM with registered outputs.
REQ-015 IDLE: both strobes high; start=1 moves to FETCH on the next edge.
REQ-016 FETCH: pcir_cs=0 for exactly CS_WIDTH cycles, then WAIT_GO.
REQ-017 WAIT_GO: both strobes high; moves to EXEC on the edge where go_s=1 and fin_s=0.
REQ-018 EXEC: alu_cs=0 for exactly CS_WIDTH cycles, then WAIT_FIN.
REQ-019 WAIT_FIN: both strobes high; when fin_s=1 and go_s=0, increment instr_cnt and move to FETCH if start=1, otherwise to IDLE.
REQ-020 A raw flag change before edge N SHALL produce the state change at edge N+2, with the strobe update visible after that edge.
REQ-021 pcir_cs and alu_cs SHALL never be low in the same cycle, and each SHALL be glitch-free (driven directly from flops).
REQ-022 Deasserting start outside IDLE SHALL NOT abort the current instruction; the pair completes, then the FSM enters IDLE.
REQ-023 instr_cnt SHALL wrap from 16'hFFFF to 16'h0000 without setting any flag.
REQ-024 A within-strobe cycle counter SHALL be 4 bits and reload on every entry to FETCH or EXEC.

Reset
REQ-025 rst=0 SHALL immediately force pcir_cs=1, alu_cs=1, busy=0, err=0, instr_cnt=0, state=IDLE, and synchronizer flops to fin_s=0, go_s=1.
REQ-026 Reset asserted mid-strobe SHALL release the strobe asynchronously; the first strobe after reset release SHALL be a full-width pcir_cs.

Configuration
REQ-027 With PIPE_SEQ_TIMEOUT_EN defined, an 8-bit wait counter SHALL run in WAIT_GO and WAIT_FIN; reaching TIMEOUT cycles moves the FSM to ERR, which sets err=1, holds both strobes high, and exits only on reset.
REQ-028 Without PIPE_SEQ_TIMEOUT_EN, no wait counter or ERR transition SHALL exist, err SHALL be tied to 0, and wait states SHALL wait indefinitely.

Structure
REQ-029 Shared package pipe_ctl_pkg SHALL hold ACTIVE=0, INACTIVE=1, FULL=1, EMPTY=0 and the state enumeration; both this block and the pipeline control unit SHALL import it.
REQ-030 The two-flop synchronizer SHALL be the sub-module flag_sync, parameterized by reset value and instantiated once per flag.

Verification
REQ-031 Reset release, start=1, ideal control-unit model: pcir_cs low 2 cycles, then alu_cs low 2 cycles; after 3 pairs, instr_cnt=3.
REQ-032 Hold goahead=0 for 10 cycles after FETCH: alu_cs stays high; alu_cs falls exactly 2 edges after goahead rises.
REQ-033 Drop start during EXEC: the pair completes, instr_cnt increments by 1, the FSM reaches IDLE, busy=0, and no further pcir_cs is issued.
REQ-034 Preload instr_cnt to 16'hFFFE by force and run 2 pairs: instr_cnt=16'h0000, err=0.
REQ-035 With PIPE_SEQ_TIMEOUT_EN and TIMEOUT=8, hold finish=0 in WAIT_FIN: err=1 after 8 wait cycles, both strobes high, err stays 1 until rst=0.
REQ-036 Assert rst=0 mid-pcir_cs: pcir_cs=1 within the same cycle; after release with start=1, the next pcir_cs is 2 cycles wide.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// Definitions shared by the strobe sequencer and the pipeline control unit:
// strobe/flag polarities and the sequencer state encoding.
package pipe_ctl_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;
    localparam logic FULL     = 1'b1;
    localparam logic EMPTY    = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_GO,
        EXEC,
        WAIT_FIN,
        ERR
    } pipe_state_t;

endpackage

// File: rtl/flag_sync.sv
// Two-flop synchronizer for a single control-unit flag; RST_VAL sets the
// value both flops take while rst is low.
module flag_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pipe_strobe_seq.sv
// Fetch/execute strobe sequencer driven by the pipeline control flags.
// Define PIPE_SEQ_TIMEOUT_EN to add the wait-state timeout and sticky err.
//
// state    | meaning
// IDLE     | not running, strobes high, waiting for start
// FETCH    | pcir_cs low for CS_WIDTH cycles
// WAIT_GO  | waiting for goahead FULL and finish EMPTY
// EXEC     | alu_cs low for CS_WIDTH cycles
// WAIT_FIN | waiting for finish FULL and goahead EMPTY, then count the pair
// ERR      | wait-state timeout, strobes high, left only through reset
module pipe_strobe_seq
    import pipe_ctl_pkg::*;
#(
    parameter int CS_WIDTH = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        finish,
    input  logic        goahead,
    output logic        pcir_cs,
    output logic        alu_cs,
    output logic        busy,
    output logic        err,
    output logic [15:0] instr_cnt
);

    localparam logic [3:0] CS_LOAD = 4'(CS_WIDTH - 1);

    if (CS_WIDTH < 1 || CS_WIDTH > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_chk
        $error("pipe_strobe_seq: CS_WIDTH or TIMEOUT out of range");
    end

    pipe_state_t state;
    logic [3:0]  cs_cnt;
    logic        fin_s;
    logic        go_s;
    logic        go_ready;
    logic        fin_ready;

    flag_sync #(.RST_VAL(EMPTY)) u_fin_sync (
        .clk (clk),
        .rst (rst),
        .d   (finish),
        .q   (fin_s)
    );

    flag_sync #(.RST_VAL(FULL)) u_go_sync (
        .clk (clk),
        .rst (rst),
        .d   (goahead),
        .q   (go_s)
    );

    assign go_ready  = (go_s == FULL) && (fin_s == EMPTY);
    assign fin_ready = (fin_s == FULL) && (go_s == EMPTY);

`ifdef PIPE_SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pcir_cs   <= INACTIVE;
            alu_cs    <= INACTIVE;
            busy      <= 1'b0;
            instr_cnt <= 16'h0000;
            cs_cnt    <= 4'd0;
`ifdef PIPE_SEQ_TIMEOUT_EN
            wait_cnt  <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        pcir_cs <= ACTIVE;
                        busy    <= 1'b1;
                        cs_cnt  <= CS_LOAD;
                    end
                end
                FETCH: begin
                    if (cs_cnt == 4'd0) begin
                        state   <= WAIT_GO;
                        pcir_cs <= INACTIVE;
`ifdef PIPE_SEQ_TIMEOUT_EN
                        wait_cnt <= WAIT_LOAD;
`endif
                    end else begin
                        cs_cnt <= cs_cnt - 4'd1;
                    end
                end
                WAIT_GO: begin
                    if (go_ready) begin
                        state  <= EXEC;
                        alu_cs <= ACTIVE;
                        cs_cnt <= CS_LOAD;
                    end
`ifdef PIPE_SEQ_TIMEOUT_EN
                    else if (wait_cnt == 8'd0) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
`endif
                end
                EXEC: begin
                    if (cs_cnt == 4'd0) begin
                        state  <= WAIT_FIN;
                        alu_cs <= INACTIVE;
`ifdef PIPE_SEQ_TIMEOUT_EN
                        wait_cnt <= WAIT_LOAD;
`endif
                    end else begin
                        cs_cnt <= cs_cnt - 4'd1;
                    end
                end
                WAIT_FIN: begin
                    // start is only sampled here, so dropping it never cuts a pair short
                    if (fin_ready) begin
                        instr_cnt <= instr_cnt + 16'd1;
                        if (start) begin
                            state   <= FETCH;
                            pcir_cs <= ACTIVE;
                            cs_cnt  <= CS_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
`ifdef PIPE_SEQ_TIMEOUT_EN
                    else if (wait_cnt == 8'd0) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
`endif
                end
                ERR: begin
                    pcir_cs <= INACTIVE;
                    alu_cs  <= INACTIVE;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    pcir_cs <= INACTIVE;
                    alu_cs  <= INACTIVE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
